rect_plot_scheduler: RTL
========================

Name: rect_plot_scheduler

Overview:
- Owns the single VGA pixel-write port (oX/oY/oColour/oPlot) and shares it between two rectangle-draw requesters.
- Channel A is the player erase/draw engine. Channel B is the background/obstacle painter.
- Each granted request rasterises one solid rectangle, one pixel per clock, then acknowledges the requester.
- Round-robin arbitration so neither requester starves. Sits between the game control FSM and the VGA adapter.

Parameters:
- X_SCREEN_PIXELS, 160, pixels with x >= this are clipped (no plot).
- Y_SCREEN_PIXELS, 120, pixels with y >= this are clipped (no plot).

Ports:
- iClock  in  1  system clock; all state changes on rising edge.
- iResetn  in  1  asynchronous active-low reset.
- iReqA  in  1  channel A request (level); held until ackA.
- iXA  in  8  channel A rectangle top-left x.
- iYA  in  7  channel A rectangle top-left y.
- iWA  in  4  channel A width in pixels (0..15).
- iHA  in  4  channel A height in pixels (0..15).
- iColA  in  3  channel A colour.
- oAckA  out  1  one-cycle pulse: channel A rectangle finished.
- iReqB, iXB, iYB, iWB, iHB, iColB  in  1/8/7/4/4/3  channel B, same meaning as A.
- oAckB  out  1  one-cycle pulse: channel B rectangle finished.
- oX  out  8  pixel x to VGA.
- oY  out  7  pixel y to VGA.
- oColour  out  3  pixel colour.
- oPlot  out  1  pixel write enable.
- oBusy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, iResetn=0): state IDLE; oX=0, oY=0, oColour=0, oPlot=0, oAckA=0, oAckB=0, oBusy=0; round-robin pointer = "B last served", so A wins the first tie. Applies immediately, including mid-rectangle; the partial rectangle is abandoned and never acked.
- States: IDLE, LOAD, PLOT, ACK.
- IDLE: on an edge with any request high, pick the winner and latch its x, y, w, h, colour and channel id; go to LOAD.
  - Only one request high: it wins.
  - Both high: the channel not served last wins.
  - Fields are sampled only on this edge; later changes are ignored.
- LOAD: clear col/row counters, set oBusy.
  - w=0 or h=0: go directly to ACK, no plot.
  - Otherwise go to PLOT.
- PLOT: one pixel per cycle, all outputs registered.
  - oX = x0+col (9-bit internal sum), oY = y0+row (8-bit internal sum), oColour = latched colour.
  - oPlot = 1 unless the sum is >= X_SCREEN_PIXELS / >= Y_SCREEN_PIXELS; clipped pixels still consume their cycle with oPlot=0 and oX/oY truncated.
  - Raster order: col increments fastest; when col = w-1, col wraps to 0 and row increments.
  - After pixel (w-1, h-1) go to ACK. A w×h rectangle occupies exactly w*h PLOT cycles.
- ACK: oPlot=0; pulse the granted channel's oAck for exactly one cycle; update the round-robin pointer; return to IDLE.
- Latency: from the request-sampling edge, the first pixel is valid 2 cycles later and ack is valid (w*h)+2 cycles later. Minimum request-to-request turnaround is w*h+3 cycles.
- Handshake:
  - A requester may drop req in the ack cycle.
  - A req still high in the IDLE cycle after ack counts as a new request and is arbitrated round-robin.
  - Dropping req before ack is ignored; the rectangle completes and is acked anyway.
- A request arriving while oBusy=1 waits; the other channel is never pre-empted.

Test Plan:
- Single rectangle: after reset, iReqA=1, (iXA,iYA)=(10,10), iWA=iHA=2, iColA=3'b100 -> oPlot high 4 consecutive cycles at (10,10),(11,10),(10,11),(11,11), colour 4; oAckA one cycle, 2+4 cycles after the sampling edge; oBusy low afterwards.
- Tie after reset: iReqA and iReqB both high on the same edge, each 1×1 -> A plotted and acked first, then B; exactly one pixel each, in order A, B.
- Fairness: both requests held high continuously, each 1×1 -> grants alternate A,B,A,B across 4 rectangles; no channel served twice in a row.
- Degenerate and clipping: iWA=0 -> oAckA with zero oPlot cycles. Then iXB=158, iYB=119, iWB=4, iHB=1 -> 4 PLOT cycles, oPlot=1 for x=158,159 and 0 for x=160,161.
- Reset mid-operation: 4×4 rectangle, iResetn low after the 5th pixel -> all outputs 0 immediately, no oAckA. After release, a new B request is served before A (pointer reset to A-first applies only on a tie, so B alone wins).

Source files
------------

// File: rtl/rect_plot_scheduler.sv
// Shares the single VGA pixel-write port between two rectangle requesters,
// rasterising one solid rectangle per grant at one pixel per clock.
module rect_plot_scheduler #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iReqA,
  input  logic [7:0] iXA,
  input  logic [6:0] iYA,
  input  logic [3:0] iWA,
  input  logic [3:0] iHA,
  input  logic [2:0] iColA,
  output logic       oAckA,
  input  logic       iReqB,
  input  logic [7:0] iXB,
  input  logic [6:0] iYB,
  input  logic [3:0] iWB,
  input  logic [3:0] iHB,
  input  logic [2:0] iColB,
  output logic       oAckB,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic       oBusy
);

  typedef enum logic [1:0] {IDLE, LOAD, PLOT, ACK} state_t;

  localparam logic [8:0] X_LIM = 9'(X_SCREEN_PIXELS);
  localparam logic [7:0] Y_LIM = 8'(Y_SCREEN_PIXELS);

  state_t     state;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [3:0] w;
  logic [3:0] h;
  logic [3:0] col;
  logic [3:0] row;
  logic [2:0] colour;
  logic       chan_b;
  logic       last_b;
  logic       grant_b;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  // Sums are one bit wider than the port so off-screen pixels can be detected.
  assign sum_x = {1'b0, x0} + {5'd0, col};
  assign sum_y = {1'b0, y0} + {4'd0, row};
  assign oBusy = (state != IDLE);

  always_comb begin
    grant_b = iReqB && (!iReqA || !last_b);
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state   <= IDLE;
      x0      <= '0;
      y0      <= '0;
      w       <= '0;
      h       <= '0;
      col     <= '0;
      row     <= '0;
      colour  <= '0;
      chan_b  <= 1'b0;
      last_b  <= 1'b1;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
      oAckA   <= 1'b0;
      oAckB   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          oAckA <= 1'b0;
          oAckB <= 1'b0;
          oPlot <= 1'b0;
          if (iReqA || iReqB) begin
            chan_b <= grant_b;
            x0     <= grant_b ? iXB   : iXA;
            y0     <= grant_b ? iYB   : iYA;
            w      <= grant_b ? iWB   : iWA;
            h      <= grant_b ? iHB   : iHA;
            colour <= grant_b ? iColB : iColA;
            state  <= LOAD;
          end
        end
        LOAD: begin
          col   <= '0;
          row   <= '0;
          oPlot <= 1'b0;
          state <= (w == 4'd0 || h == 4'd0) ? ACK : PLOT;
        end
        PLOT: begin
          oX      <= sum_x[7:0];
          oY      <= sum_y[6:0];
          oColour <= colour;
          oPlot   <= (sum_x < X_LIM) && (sum_y < Y_LIM);
          if (col == w - 4'd1) begin
            col <= '0;
            if (row == h - 4'd1) begin
              state <= ACK;
            end else begin
              row <= row + 4'd1;
            end
          end else begin
            col <= col + 4'd1;
          end
        end
        ACK: begin
          oPlot  <= 1'b0;
          oAckA  <= !chan_b;
          oAckB  <= chan_b;
          last_b <= chan_b;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
